// File: rtl/kt_sequencer.sv
// Streams the 64 SHA-256 round constants Kt out of a 256x16 RAM pair with a
// valid/ready handshake; a one-entry skid plus the RAM's held read data absorb stalls.
module kt_sequencer #(
    parameter logic [1:0] RAM_BASE = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  ram_raddr,
    output logic        ram_re,
    input  logic [15:0] ram_rdata_hi,
    input  logic [15:0] ram_rdata_lo,
    output logic [31:0] kt,
    output logic [5:0]  kt_round,
    output logic        kt_valid,
    input  logic        kt_ready,
    output logic        kt_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [6:0]  issue_cnt;
    logic        pend_p0;
    logic [5:0]  pend_round_p0;
    logic        skid_vld_p1;
    logic [31:0] skid_kt_p1;
    logic [5:0]  skid_round_p1;

    logic        xfer;
    logic        out_free;
    logic        take_pend;
    logic        issue;
    logic        last_xfer;
    logic [1:0]  occ;
    logic [31:0] rdata;

    // pend_p0 marks an unconsumed word on the RAM outputs; the RAM holds it
    // while ram_re is low, so it only has to be absorbed before the next read lands.
    always_comb begin
        rdata     = {ram_rdata_hi, ram_rdata_lo};
        xfer      = kt_valid & kt_ready;
        out_free  = ~kt_valid | xfer;
        take_pend = pend_p0 & (out_free | ~skid_vld_p1);
        occ       = {1'b0, kt_valid} + {1'b0, skid_vld_p1} + {1'b0, pend_p0};
        issue     = (state == RUN) && !issue_cnt[6] && ((occ - {1'b0, xfer}) < 2'd2);
        last_xfer = xfer && (kt_round == 6'd63);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            issue_cnt     <= 7'd0;
            ram_re        <= 1'b0;
            ram_raddr     <= {RAM_BASE, 6'd0};
            busy          <= 1'b0;
            done          <= 1'b0;
            pend_p0       <= 1'b0;
            pend_round_p0 <= 6'd0;
            skid_vld_p1   <= 1'b0;
            skid_kt_p1    <= 32'd0;
            skid_round_p1 <= 6'd0;
            kt            <= 32'd0;
            kt_round      <= 6'd0;
            kt_valid      <= 1'b0;
            kt_last       <= 1'b0;
        end else begin
            ram_re <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        ram_re    <= 1'b1;
                        ram_raddr <= {RAM_BASE, 6'd0};
                        issue_cnt <= 7'd1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        ram_re    <= 1'b1;
                        ram_raddr <= {RAM_BASE, issue_cnt[5:0]};
                        issue_cnt <= issue_cnt + 7'd1;
                    end
                    if (last_xfer) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // p0: word on the RAM outputs, tagged with the round that was read
            if (ram_re)
                pend_round_p0 <= ram_raddr[5:0];
            pend_p0 <= ram_re | (pend_p0 & ~take_pend);

            // p1: skid entry and output register
            if (out_free) begin
                if (skid_vld_p1) begin
                    kt          <= skid_kt_p1;
                    kt_round    <= skid_round_p1;
                    kt_last     <= (skid_round_p1 == 6'd63);
                    kt_valid    <= 1'b1;
                    skid_vld_p1 <= pend_p0;
                    if (pend_p0) begin
                        skid_kt_p1    <= rdata;
                        skid_round_p1 <= pend_round_p0;
                    end
                end else if (pend_p0) begin
                    kt       <= rdata;
                    kt_round <= pend_round_p0;
                    kt_last  <= (pend_round_p0 == 6'd63);
                    kt_valid <= 1'b1;
                end else begin
                    kt_valid <= 1'b0;
                    kt_last  <= 1'b0;
                end
            end else if (pend_p0 && !skid_vld_p1) begin
                skid_kt_p1    <= rdata;
                skid_round_p1 <= pend_round_p0;
                skid_vld_p1   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kt_sequencer.sv
// Scoreboard bench for kt_sequencer: expected Kt stream queued at start, popped
// by a monitor on every accepted transfer; a second instance covers RAM_BASE=01.
module tb_kt_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  ram_raddr;
    logic        ram_re;
    logic [15:0] ram_rdata_hi;
    logic [15:0] ram_rdata_lo;
    logic [31:0] kt;
    logic [5:0]  kt_round;
    logic        kt_valid;
    logic        kt_ready;
    logic        kt_last;
    logic        busy;
    logic        done;

    logic        start_b;
    logic [7:0]  ram_raddr_b;
    logic        ram_re_b;
    logic [15:0] ram_rdata_hi_b;
    logic [15:0] ram_rdata_lo_b;
    logic [31:0] kt_b;
    logic [5:0]  kt_round_b;
    logic        kt_valid_b;
    logic        kt_ready_b;
    logic        kt_last_b;
    logic        busy_b;
    logic        done_b;

    always #5 clk = ~clk;

    kt_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .ram_raddr(ram_raddr), .ram_re(ram_re),
        .ram_rdata_hi(ram_rdata_hi), .ram_rdata_lo(ram_rdata_lo),
        .kt(kt), .kt_round(kt_round), .kt_valid(kt_valid), .kt_ready(kt_ready),
        .kt_last(kt_last), .busy(busy), .done(done)
    );

    kt_sequencer #(.RAM_BASE(2'b01)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .ram_raddr(ram_raddr_b), .ram_re(ram_re_b),
        .ram_rdata_hi(ram_rdata_hi_b), .ram_rdata_lo(ram_rdata_lo_b),
        .kt(kt_b), .kt_round(kt_round_b), .kt_valid(kt_valid_b), .kt_ready(kt_ready_b),
        .kt_last(kt_last_b), .busy(busy_b), .done(done_b)
    );

    // RAM model: hi[a]=a, lo[a]=0x100+a, registered read, output held when re is low
    always @(posedge clk) begin
        if (ram_re) begin
            ram_rdata_hi <= {8'h00, ram_raddr};
            ram_rdata_lo <= 16'h0100 + {8'h00, ram_raddr};
        end
        if (ram_re_b) begin
            ram_rdata_hi_b <= {8'h00, ram_raddr_b};
            ram_rdata_lo_b <= 16'h0100 + {8'h00, ram_raddr_b};
        end
    end

    typedef struct {
        logic [31:0] kt;
        logic [5:0]  rnd;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   fails   = 0;
    int   re_cnt, done_cnt, xfers;

    function automatic logic [31:0] kt_ref(input logic [1:0] base, input int r);
        logic [15:0] a;
        a = 16'(base) * 16'd64 + 16'(r);
        return {a, 16'h0100 + a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted transfer, checks stall stability
    initial begin
        logic        stalled;
        logic [31:0] held_kt;
        logic [5:0]  held_rnd;
        exp_t        e;
        stalled = 1'b0;
        held_kt = '0;
        held_rnd = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", 64'(kt_valid), 64'd1);
                    chk("hold_kt", 64'(kt), 64'(held_kt));
                    chk("hold_round", 64'(kt_round), 64'(held_rnd));
                end
                if (kt_valid && kt_ready) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_xfer", 64'(kt), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_kt", 64'(kt), 64'(e.kt));
                        chk("sb_round", 64'(kt_round), 64'(e.rnd));
                        chk("sb_last", 64'(kt_last), 64'(e.last));
                    end
                end
                stalled  = kt_valid && !kt_ready;
                held_kt  = kt;
                held_rnd = kt_round;
                if (ram_re) re_cnt++;
                if (done) done_cnt++;
            end
        end
    end

    // mode 0: ready held high, 1: ready low in cycles 10..14, 2: random ready
    task automatic run_stream(input int mode, input int restart_at, input int reset_at);
        int   after_done;
        logic seen_done;
        exp_t e;
        re_cnt = 0;
        done_cnt = 0;
        xfers = 0;
        seen_done = 1'b0;
        after_done = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            start = (k == 0) || (k == restart_at);
            reset = (k == reset_at);
            case (mode)
                1:       kt_ready = !(k >= 10 && k <= 14);
                2:       kt_ready = 1'($urandom_range(0, 1));
                default: kt_ready = 1'b1;
            endcase
            if (k == 0) begin
                for (int r = 0; r < 64; r++) begin
                    e.kt = kt_ref(2'b10, r);
                    e.rnd = 6'(r);
                    e.last = (r == 63);
                    exp_q.push_back(e);
                end
            end
            if (k == reset_at) exp_q.delete();
            @(negedge clk);
            if (mode == 0 && restart_at < 0 && reset_at < 0) begin
                if (k == 0) chk("busy_c0", 64'(busy), 64'd0);
                if (k == 1) chk("busy_c1", 64'(busy), 64'd1);
                if (k == 2) chk("valid_c2", 64'(kt_valid), 64'd0);
                if (k == 3) begin
                    chk("valid_c3", 64'(kt_valid), 64'd1);
                    chk("kt_c3", 64'(kt), 64'h0080_0180);
                    chk("round_c3", 64'(kt_round), 64'd0);
                end
                if (k == 66) begin
                    chk("last_c66", 64'(kt_last), 64'd1);
                    chk("kt_c66", 64'(kt), 64'h00BF_01BF);
                    chk("done_c66", 64'(done), 64'd0);
                end
                if (k == 67) begin
                    chk("done_c67", 64'(done), 64'd1);
                    chk("busy_c67", 64'(busy), 64'd0);
                    chk("valid_c67", 64'(kt_valid), 64'd0);
                end
            end
            if (reset_at >= 0 && k == reset_at + 1) begin
                chk("rst_valid", 64'(kt_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_kt", 64'(kt), 64'd0);
                chk("rst_re", 64'(ram_re), 64'd0);
                chk("rst_raddr", 64'(ram_raddr), 64'h80);
                chk("rst_done", 64'(done), 64'd0);
            end
            if (done) seen_done = 1'b1;
            if (seen_done) after_done++;
            if (after_done > 2) break;
            if (reset_at >= 0 && k > reset_at + 80) break;
        end
        start = 1'b0;
        reset = 1'b0;
        kt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (reset_at >= 0) begin
            chk("rst_no_done", 64'(done_cnt), 64'd0);
        end else begin
            chk("done_count", 64'(done_cnt), 64'd1);
            chk("re_count", 64'(re_cnt), 64'd64);
            chk("xfer_count", 64'(xfers), 64'd64);
            chk("sb_empty", 64'(exp_q.size()), 64'd0);
        end
    endtask

    initial begin
        int idx;
        logic first_seen, b_done;
        reset = 1'b1;
        start = 1'b0;
        kt_ready = 1'b1;
        start_b = 1'b0;
        kt_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_raddr", 64'(ram_raddr), 64'h80);
        chk("reset_re", 64'(ram_re), 64'd0);
        chk("reset_valid", 64'(kt_valid), 64'd0);
        chk("reset_kt", 64'(kt), 64'd0);
        chk("reset_busy_done", 64'({busy, done, kt_last}), 64'd0);
        chk("reset_round", 64'(kt_round), 64'd0);

        run_stream(0, -1, -1);
        run_stream(1, -1, -1);
        run_stream(2, -1, -1);
        run_stream(2, -1, -1);
        run_stream(0, 20, -1);
        run_stream(0, -1, 30);
        run_stream(0, -1, -1);

        idx = 0;
        first_seen = 1'b0;
        b_done = 1'b0;
        for (int k = 0; k < 200 && !b_done; k++) begin
            @(posedge clk);
            #1;
            start_b = (k == 0);
            @(negedge clk);
            if (ram_re_b) begin
                chk("b_raddr", 64'(ram_raddr_b), 64'(8'h40 + 8'(idx)));
                idx++;
            end
            if (kt_valid_b && !first_seen) begin
                first_seen = 1'b1;
                chk("b_kt_r0", 64'(kt_b), 64'h0040_0140);
                chk("b_round_r0", 64'(kt_round_b), 64'd0);
            end
            if (done_b) b_done = 1'b1;
        end
        start_b = 1'b0;
        chk("b_issues", 64'(idx), 64'd64);
        chk("b_done", 64'(b_done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
